// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the MIPS control units: opcodes, funct codes,
// ALU operation codes, FSM state encoding and the control-word struct.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct codes (IR[5:0]) for R-type; F_MULT is treated as a three-operand
  // multiply writing rd, the only multiply this datapath supports.
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_AND  = 4'h1;
  localparam logic [3:0] ALU_OR   = 4'h2;
  localparam logic [3:0] ALU_NOR  = 4'h3;
  localparam logic [3:0] ALU_SLT  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SUB  = 4'h7;
  localparam logic [3:0] ALU_MUL  = 4'h8;
  localparam logic [3:0] ALU_LUI  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_JR, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILLEGAL
  } iclass_t;

  // One control word per cycle; all-zero is the idle/no-write word.
  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_neq;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_src;
    logic       jen;
    logic       jal;
    logic       sign_zero;
    logic       mem_req;
    logic [1:0] alu_src_b;
    logic [3:0] alu;
    logic       done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller-to-datapath bundle. The controller is the slave side: it
// receives the IR fields and memory status and drives every strobe.
//
// Memory handshake: MemReq is held high for the whole access; the access
// completes in the cycle MemReady=1 is seen together with MemReq=1. Any
// state change caused by the access happens on the following clock edge.
interface mips_mc_ctrl_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [5:0]            Op;
  logic [5:0]            Funct;
  logic                  MemReady;
  logic                  PCWrite;
  logic                  BranchEq;
  logic                  BranchNeq;
  logic                  IorD;
  logic                  MemWrite;
  logic                  IRWrite;
  logic                  RegDst;
  logic                  MemtoReg;
  logic                  RegWrite;
  logic                  ALUSrcA;
  logic                  PCSrc;
  logic                  Jen;
  logic                  Jal;
  logic                  SignZero;
  logic                  MemReq;
  logic [1:0]            ALUSrcB;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic [2:0]            State;
  logic                  InstrDone;
  logic                  IllegalOp;

  modport master (
    output Op, Funct, MemReady,
    input  PCWrite, BranchEq, BranchNeq, IorD, MemWrite, IRWrite,
    input  RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc, Jen, Jal, SignZero,
    input  MemReq, ALUSrcB, ALUControl, State, InstrDone, IllegalOp
  );

  modport slave (
    input  Op, Funct, MemReady,
    output PCWrite, BranchEq, BranchNeq, IorD, MemWrite, IRWrite,
    output RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc, Jen, Jal, SignZero,
    output MemReq, ALUSrcB, ALUControl, State, InstrDone, IllegalOp
  );
endinterface

// File: rtl/mips_mc_ctrl_alu_funct_dec.sv
// R-type funct to ALU operation decode. Purely combinational so the
// pipelined core can reuse it in its decode stage. jr is not an ALU
// function and is reported as not legal here; callers handle it.
module alu_funct_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  // Table lookup of the ALU operation and its legality.
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      F_ADD, F_ADDU: alu_op = ALU_ADD;
      F_SUB, F_SUBU: alu_op = ALU_SUB;
      F_AND:         alu_op = ALU_AND;
      F_OR:          alu_op = ALU_OR;
      F_NOR:         alu_op = ALU_NOR;
      F_SLT:         alu_op = ALU_SLT;
      F_SLTU:        alu_op = ALU_SLTU;
      F_SLL:         alu_op = ALU_SLL;
      F_SRL:         alu_op = ALU_SRL;
      F_MULT:        alu_op = ALU_MUL;
      default:       legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: fetch/decode/execute/memory/writeback FSM
// with memory wait states, illegal-instruction detection and a
// per-instruction completion pulse. Outputs are Moore/Mealy combinational
// from the state, the IR fields and MemReady.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W    = 4,
  parameter int MEM_HANDSHAKE = 1
) (
  input logic           CLK,
  input logic           CLR,
  mips_mc_ctrl_if.slave bus
);

  if (ALU_CTRL_W < 4) begin : g_bad_width
    $error("ALU_CTRL_W must be at least 4");
  end

  state_t     state;
  state_t     state_next;
  iclass_t    iclass;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;
  logic [3:0] funct_alu;
  logic       funct_legal;
  logic [3:0] imm_alu;
  logic       zero_ext;
  logic       ready;

  alu_funct_dec u_funct_dec (
    .funct  (bus.Funct),
    .alu_op (funct_alu),
    .legal  (funct_legal)
  );

  // With the handshake disabled every memory access completes at once.
  assign ready = (MEM_HANDSHAKE == 0) ? 1'b1 : bus.MemReady;

  // Classify the instruction held in the IR.
  always_comb begin
    iclass   = C_ILLEGAL;
    imm_alu  = ALU_ADD;
    zero_ext = 1'b0;
    case (bus.Op)
      OP_RTYPE: begin
        if (bus.Funct == F_JR) iclass = C_JR;
        else if (funct_legal)  iclass = C_RTYPE;
      end
      OP_J:     iclass = C_J;
      OP_JAL:   iclass = C_JAL;
      OP_BEQ:   iclass = C_BEQ;
      OP_BNE:   iclass = C_BNE;
      OP_LW:    iclass = C_LW;
      OP_SW:    iclass = C_SW;
      OP_ADDI:  begin iclass = C_IALU; imm_alu = ALU_ADD;  end
      OP_SLTI:  begin iclass = C_IALU; imm_alu = ALU_SLT;  end
      OP_SLTIU: begin iclass = C_IALU; imm_alu = ALU_SLTU; end
      OP_ANDI:  begin iclass = C_IALU; imm_alu = ALU_AND; zero_ext = 1'b1; end
      OP_ORI:   begin iclass = C_IALU; imm_alu = ALU_OR;  zero_ext = 1'b1; end
      OP_LUI:   begin iclass = C_IALU; imm_alu = ALU_LUI;  end
      default:  iclass = C_ILLEGAL;
    endcase
  end

  // State register; CLR returns to FETCH and abandons any instruction.
  always_ff @(posedge CLK) begin
    if (CLR) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state and control-word decode.
  always_comb begin
    ctrl       = '0;
    state_next = state;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu       = ALU_ADD;
        if (ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here for every instruction.
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu       = ALU_ADD;
        case (iclass)
          C_J: begin
            ctrl.jen      = 1'b1;
            ctrl.pc_write = 1'b1;
            ctrl.done     = 1'b1;
            state_next    = S_FETCH;
          end
          C_JAL: begin
            ctrl.jen       = 1'b1;
            ctrl.jal       = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.done      = 1'b1;
            state_next     = S_FETCH;
          end
          C_ILLEGAL: begin
            ctrl.illegal = 1'b1;
            ctrl.done    = 1'b1;
            state_next   = S_FETCH;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        case (iclass)
          C_RTYPE: begin
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu       = funct_alu;
            state_next     = S_WB;
          end
          C_IALU: begin
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu       = imm_alu;
            ctrl.sign_zero = zero_ext;
            state_next     = S_WB;
          end
          C_LW, C_SW: begin
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu       = ALU_ADD;
            state_next     = S_MEM;
          end
          C_BEQ, C_BNE: begin
            ctrl.alu_src_b  = SRCB_REG;
            ctrl.alu        = ALU_SUB;
            ctrl.pc_src     = 1'b1;
            ctrl.branch_eq  = (iclass == C_BEQ);
            ctrl.branch_neq = (iclass == C_BNE);
            ctrl.done       = 1'b1;
            state_next      = S_FETCH;
          end
          C_JR: begin
            // rt is $0 in a jr encoding, so A + B passes rs through.
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu       = ALU_ADD;
            ctrl.pc_write  = 1'b1;
            ctrl.done      = 1'b1;
            state_next     = S_FETCH;
          end
          default: begin
            // IR changed under us; drop back to fetch with no writes.
            ctrl.alu_src_a = 1'b0;
            state_next     = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        ctrl.mem_req   = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = (iclass == C_SW);
        if (ready) begin
          if (iclass == C_LW) begin
            state_next = S_WB;
          end else begin
            ctrl.done  = 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (iclass == C_RTYPE);
        ctrl.mem_to_reg = (iclass == C_LW);
        ctrl.done       = 1'b1;
        state_next      = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset silences every output immediately, not just after the edge.
  assign ctrl_out = CLR ? '0 : ctrl;

  assign bus.PCWrite    = ctrl_out.pc_write;
  assign bus.BranchEq   = ctrl_out.branch_eq;
  assign bus.BranchNeq  = ctrl_out.branch_neq;
  assign bus.IorD       = ctrl_out.i_or_d;
  assign bus.MemWrite   = ctrl_out.mem_write;
  assign bus.IRWrite    = ctrl_out.ir_write;
  assign bus.RegDst     = ctrl_out.reg_dst;
  assign bus.MemtoReg   = ctrl_out.mem_to_reg;
  assign bus.RegWrite   = ctrl_out.reg_write;
  assign bus.ALUSrcA    = ctrl_out.alu_src_a;
  assign bus.PCSrc      = ctrl_out.pc_src;
  assign bus.Jen        = ctrl_out.jen;
  assign bus.Jal        = ctrl_out.jal;
  assign bus.SignZero   = ctrl_out.sign_zero;
  assign bus.MemReq     = ctrl_out.mem_req;
  assign bus.ALUSrcB    = ctrl_out.alu_src_b;
  assign bus.ALUControl = ALU_CTRL_W'(ctrl_out.alu);
  assign bus.InstrDone  = ctrl_out.done;
  assign bus.IllegalOp  = ctrl_out.illegal;
  assign bus.State      = CLR ? 3'd0 : state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl. Each instruction is expanded into the
// per-cycle output trace it must produce; the run then replays the inputs
// cycle by cycle and compares every output against that trace.
module tb_mips_mc_ctrl;

  localparam int W = 26;

  typedef struct packed {
    logic       pcw;
    logic       beq;
    logic       bne;
    logic       iord;
    logic       memw;
    logic       irw;
    logic       regdst;
    logic       memtoreg;
    logic       regw;
    logic       srca;
    logic       pcsrc;
    logic       jen;
    logic       jal;
    logic       signzero;
    logic       memreq;
    logic [1:0] srcb;
    logic [3:0] alu;
    logic [2:0] state;
    logic       done;
    logic       illegal;
  } exp_t;

  localparam int K_R = 0, K_JR = 1, K_I = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mips_mc_ctrl_if #(.ALU_CTRL_W(4)) bus ();

  mips_mc_ctrl #(.ALU_CTRL_W(4), .MEM_HANDSHAKE(1)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  // ---------------- model tables ----------------
  int r_alu[int];
  int i_alu[int];
  logic [W-1:0] exp_q[$];
  logic [13:0]  stim_q[$];   // {clr, ready, op, funct}
  int vectors = 0;
  int miscompares = 0;

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h08) return K_JR;
      return r_alu.exists(int'(fn)) ? K_R : K_ILL;
    end
    if (i_alu.exists(int'(op))) return K_I;
    case (op)
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      default: return K_ILL;
    endcase
  endfunction

  function automatic exp_t blank(input int st);
    exp_t e;
    e = '0;
    e.state = st[2:0];
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input bit c, input bit rdy, input logic [5:0] op,
                      input logic [5:0] fn, input exp_t e);
    stim_q.push_back({c, rdy, op, fn});
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 6'h00, 6'h00, blank(0));
  endtask

  // Expands one instruction into its cycle trace. abort places a reset
  // after the first memory wait cycle.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input int fetch_wait, input int mem_wait,
                       input bit abort);
    exp_t e;
    int k;
    k = kind(op, fn);
    for (int i = 0; i < fetch_wait; i++) begin
      e = blank(0); e.memreq = 1; e.srcb = 2'b01;
      push(1'b0, 1'b0, op, fn, e);
    end
    e = blank(0); e.memreq = 1; e.srcb = 2'b01; e.irw = 1; e.pcw = 1;
    push(1'b0, 1'b1, op, fn, e);
    e = blank(1); e.srcb = 2'b11;
    if (k == K_J)   begin e.jen = 1; e.pcw = 1; e.done = 1; end
    if (k == K_JAL) begin e.jen = 1; e.jal = 1; e.pcw = 1; e.regw = 1; e.done = 1; end
    if (k == K_ILL) begin e.illegal = 1; e.done = 1; end
    push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
    if (k == K_J || k == K_JAL || k == K_ILL) return;
    e = blank(2); e.srca = 1;
    case (k)
      K_R:  begin e.srcb = 2'b00; e.alu = 4'(r_alu[int'(fn)]); end
      K_I:  begin e.srcb = 2'b10; e.alu = 4'(i_alu[int'(op)]);
                  e.signzero = (op == 6'h0C || op == 6'h0D); end
      K_LW, K_SW: begin e.srcb = 2'b10; e.alu = 4'h0; end
      K_BEQ, K_BNE: begin e.srcb = 2'b00; e.alu = 4'h7; e.pcsrc = 1;
                  e.beq = (k == K_BEQ); e.bne = (k == K_BNE); e.done = 1; end
      default: begin e.srcb = 2'b00; e.alu = 4'h0; e.pcw = 1; e.done = 1; end
    endcase
    push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
    if (k == K_BEQ || k == K_BNE || k == K_JR) return;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < mem_wait; i++) begin
        e = blank(3); e.memreq = 1; e.iord = 1; e.memw = (k == K_SW);
        push(1'b0, 1'b0, op, fn, e);
        if (abort) begin
          do_reset(1);
          return;
        end
      end
      e = blank(3); e.memreq = 1; e.iord = 1; e.memw = (k == K_SW);
      e.done = (k == K_SW);
      push(1'b0, 1'b1, op, fn, e);
      if (k == K_SW) return;
    end
    e = blank(4); e.regw = 1; e.done = 1;
    e.regdst = (k == K_R); e.memtoreg = (k == K_LW);
    push(1'b0, 1'($urandom_range(0, 1)), op, fn, e);
  endtask

  // Pins the model against hand-computed numbers.
  task automatic pin(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int n;
    exp_t e;
    exp_t a;
    logic [13:0] s;
    int cyc;

    clr = 1'b1;
    bus.Op = 6'h00;
    bus.Funct = 6'h00;
    bus.MemReady = 1'b0;

    r_alu[32'h20] = 0; r_alu[32'h21] = 0; r_alu[32'h22] = 7; r_alu[32'h23] = 7;
    r_alu[32'h24] = 1; r_alu[32'h25] = 2; r_alu[32'h27] = 3; r_alu[32'h2A] = 4;
    r_alu[32'h2B] = 10; r_alu[32'h00] = 5; r_alu[32'h02] = 6; r_alu[32'h18] = 8;
    i_alu[32'h08] = 0; i_alu[32'h0A] = 4; i_alu[32'h0B] = 10;
    i_alu[32'h0C] = 1; i_alu[32'h0D] = 2; i_alu[32'h0F] = 9;

    do_reset(2);
    n = exp_q.size(); issue(6'h00, 6'h20, 0, 0, 0);
    pin("add_len", exp_q.size() - n, 4);
    e = exp_t'(exp_q[n + 3]);
    pin("add_wb_regdst", int'(e.regdst) + int'(e.regw) + int'(e.done), 3);
    n = exp_q.size(); issue(6'h23, 6'h00, 0, 3, 0);
    pin("lw_len", exp_q.size() - n, 8);
    n = exp_q.size(); issue(6'h05, 6'h00, 0, 0, 0);
    pin("bne_len", exp_q.size() - n, 3);
    e = exp_t'(exp_q[n + 2]);
    pin("bne_alu", int'(e.alu), 7);
    n = exp_q.size(); issue(6'h03, 6'h00, 0, 0, 0);
    pin("jal_len", exp_q.size() - n, 2);
    n = exp_q.size(); issue(6'h3F, 6'h00, 0, 0, 0);
    pin("illegal_len", exp_q.size() - n, 2);
    n = exp_q.size(); issue(6'h2B, 6'h00, 1, 2, 1);
    pin("sw_abort_len", exp_q.size() - n, 6);
    n = exp_q.size(); issue(6'h2B, 6'h00, 0, 0, 0);
    pin("sw_len", exp_q.size() - n, 4);
    issue(6'h00, 6'h22, 2, 0, 0);   // sub with fetch waits
    issue(6'h00, 6'h2B, 0, 0, 0);   // sltu
    issue(6'h00, 6'h00, 0, 0, 0);   // sll
    issue(6'h00, 6'h02, 0, 0, 0);   // srl
    issue(6'h0C, 6'h00, 1, 0, 0);   // andi
    issue(6'h0D, 6'h00, 0, 0, 0);   // ori
    issue(6'h08, 6'h00, 0, 0, 0);   // addi
    issue(6'h0F, 6'h00, 0, 0, 0);   // lui
    issue(6'h0B, 6'h00, 0, 0, 0);   // sltiu
    issue(6'h04, 6'h00, 0, 0, 0);   // beq
    issue(6'h02, 6'h00, 0, 0, 0);   // j
    issue(6'h00, 6'h08, 0, 0, 0);   // jr
    issue(6'h00, 6'h3F, 0, 0, 0);   // illegal funct
    issue(6'h00, 6'h18, 0, 0, 0);   // mul
    issue(6'h2B, 6'h00, 2, 2, 0);   // sw with waits
    issue(6'h23, 6'h00, 0, 0, 0);   // lw, no waits
    do_reset(1);

    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_t'(exp_q.pop_front());
      @(negedge clk);
      {clr, bus.MemReady, bus.Op, bus.Funct} = s;
      #1;
      a = '0;
      a.pcw = bus.PCWrite;       a.beq = bus.BranchEq;
      a.bne = bus.BranchNeq;     a.iord = bus.IorD;
      a.memw = bus.MemWrite;     a.irw = bus.IRWrite;
      a.regdst = bus.RegDst;     a.memtoreg = bus.MemtoReg;
      a.regw = bus.RegWrite;     a.srca = bus.ALUSrcA;
      a.pcsrc = bus.PCSrc;       a.jen = bus.Jen;
      a.jal = bus.Jal;           a.signzero = bus.SignZero;
      a.memreq = bus.MemReq;     a.srcb = bus.ALUSrcB;
      a.alu = bus.ALUControl;    a.state = bus.State;
      a.done = bus.InstrDone;    a.illegal = bus.IllegalOp;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle %0d op=%h funct=%h: got %h, expected %h",
                 cyc, s[11:6], s[5:0], a, e);
      end
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
